// File: rtl/tag_release_buffer.sv
// tag_release_buffer: circular buffer between the commit stage and the tag
// free list. Accepts up to two freed tags per cycle (slot 0 older) and
// returns them one per cycle, in commit order, whenever the free list has room.
module tag_release_buffer #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rel_valid_0,
    input  logic [7:0] rel_tag_0,
    input  logic       rel_valid_1,
    input  logic [7:0] rel_tag_1,
    output logic       rel_ready,
    input  logic [7:0] fl_freespace,
    output logic       write_tag,
    output logic [7:0] write_tag_source,
    output logic [7:0] num_pending,
    output logic       overflow
);

    localparam int         PTR_W   = $clog2(DEPTH);
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [7:0] entries [DEPTH];
    logic [7:0] head;
    logic [7:0] tail;
    logic [7:0] count;

    logic [8:0] space;
    logic [1:0] n_valid;
    logic [1:0] accepted;
    logic [7:0] first_tag;
    logic [7:0] tail_p1;
    logic       dropped;
    logic       pop;

    // Pointer advance by 0..2 with wrap; p < DEPTH and n <= 2 keep the sum
    // below 2*DEPTH, so a single conditional subtract is enough.
    function automatic logic [7:0] ptr_add(input logic [7:0] p, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, p} + {7'b0, n};
        if (s >= DEPTH_L) begin
            s = s - DEPTH_L;
        end
        return s[7:0];
    endfunction

    // Accept/drop decision uses the registered count, before any pop this cycle.
    always_comb begin
        space     = DEPTH_L - {1'b0, count};
        n_valid   = {1'b0, rel_valid_0} + {1'b0, rel_valid_1};
        accepted  = n_valid;
        if ({7'b0, n_valid} > space) begin
            accepted = space[1:0];
        end
        dropped   = (accepted != n_valid);
        first_tag = rel_valid_0 ? rel_tag_0 : rel_tag_1;
        tail_p1   = ptr_add(tail, 2'd1);
        pop       = (count != 8'd0) && (fl_freespace != 8'd0);
    end

    assign write_tag        = pop;
    assign write_tag_source = (count != 8'd0) ? entries[head[PTR_W-1:0]] : 8'h00;
    assign rel_ready        = (space >= 9'd2);
    assign num_pending      = count;

    // Control state: pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            head     <= 8'd0;
            tail     <= 8'd0;
            count    <= 8'd0;
            overflow <= 1'b0;
        end else begin
            tail  <= ptr_add(tail, accepted);
            head  <= pop ? ptr_add(head, 2'd1) : head;
            count <= count + {6'b0, accepted} - {7'b0, pop};
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

    // Tag storage: compacted writes at tail and tail+1; not reset.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (accepted != 2'd0) begin
                entries[tail[PTR_W-1:0]] <= first_tag;
            end
            if (accepted == 2'd2) begin
                entries[tail_p1[PTR_W-1:0]] <= rel_tag_1;
            end
        end
    end

endmodule

// File: tb/tb_tag_release_buffer.sv
// Bench for tag_release_buffer: two instances (DEPTH 8 and 5) share stimulus
// and are compared every cycle against a queue-based reference model, plus
// directed checks with fixed expected values.
module tb_tag_release_buffer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       v0, v1;
    logic [7:0] t0, t1, fs;
    logic       wt  [2];
    logic       rr  [2];
    logic       ov  [2];
    logic [7:0] src [2];
    logic [7:0] np  [2];

    always #5 clk = ~clk;

    tag_release_buffer #(.DEPTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .rel_valid_0(v0), .rel_tag_0(t0), .rel_valid_1(v1), .rel_tag_1(t1),
        .rel_ready(rr[0]), .fl_freespace(fs), .write_tag(wt[0]),
        .write_tag_source(src[0]), .num_pending(np[0]), .overflow(ov[0])
    );

    tag_release_buffer #(.DEPTH(5)) dut5 (
        .clk(clk), .reset_n(reset_n),
        .rel_valid_0(v0), .rel_tag_0(t0), .rel_valid_1(v1), .rel_tag_1(t1),
        .rel_ready(rr[1]), .fl_freespace(fs), .write_tag(wt[1]),
        .write_tag_source(src[1]), .num_pending(np[1]), .overflow(ov[1])
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] mq [2][$];
    int         md [2] = '{8, 5};
    bit         mov [2] = '{1'b0, 1'b0};
    bit         model_en = 1'b0;
    bit         log_en = 1'b0;
    logic [7:0] wlog [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: compare outputs to the model, apply the cycle's
    // inputs to the model, then advance to just after the next rising edge.
    task automatic step();
        #1;
        for (int i = 0; i < 2; i++) begin
            int         sz;
            int         space;
            logic       ew;
            logic [7:0] es;
            string      nm;
            sz = mq[i].size();
            ew = (sz != 0) && (fs != 8'd0);
            es = (sz != 0) ? mq[i][0] : 8'h00;
            nm = (i == 0) ? "d8" : "d5";
            if (model_en) begin
                check({nm, "_np"},  32'(np[i]),  32'(sz));
                check({nm, "_wt"},  32'(wt[i]),  32'(ew));
                check({nm, "_src"}, 32'(src[i]), 32'(es));
                check({nm, "_rr"},  32'(rr[i]),  32'((md[i] - sz) >= 2));
                check({nm, "_ov"},  32'(ov[i]),  32'(mov[i]));
            end
            if (i == 1 && log_en && wt[1] === 1'b1) wlog.push_back(src[1]);
            if (!reset_n) begin
                mq[i].delete();
                mov[i] = 1'b0;
            end else begin
                space = md[i] - sz;
                if (ew) void'(mq[i].pop_front());
                if (v0) begin
                    if (space > 0) begin mq[i].push_back(t0); space--; end
                    else mov[i] = 1'b1;
                end
                if (v1) begin
                    if (space > 0) begin mq[i].push_back(t1); space--; end
                    else mov[i] = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v0 = 1'b0; v1 = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int idx;
        int cyc;
        @(negedge clk);
        // Reset with a release pending that must be ignored
        reset_n = 1'b0; v0 = 1'b1; t0 = 8'h11; v1 = 1'b0; t1 = 8'h00; fs = 8'd2;
        step();
        model_en = 1'b1;
        step();
        reset_n = 1'b1; v0 = 1'b0;
        check("rst_np",  32'(np[0]),  32'd0);
        check("rst_wt",  32'(wt[0]),  32'd0);
        check("rst_rr",  32'(rr[0]),  32'd1);
        check("rst_ov",  32'(ov[0]),  32'd0);
        check("rst_src", 32'(src[0]), 32'h00);
        step();
        step();

        // Dual release, no same-cycle bypass
        fs = 8'd3; v0 = 1'b1; t0 = 8'h21; v1 = 1'b1; t1 = 8'h22;
        #1 check("dual_c0_wt", 32'(wt[0]), 32'd0);
        step();
        v0 = 1'b0; v1 = 1'b0;
        check("dual_c1_wt",  32'(wt[0]),  32'd1);
        check("dual_c1_src", 32'(src[0]), 32'h21);
        check("dual_c1_np",  32'(np[0]),  32'd2);
        step();
        check("dual_c2_wt",  32'(wt[0]),  32'd1);
        check("dual_c2_src", 32'(src[0]), 32'h22);
        check("dual_c2_np",  32'(np[0]),  32'd1);
        step();
        check("dual_c3_wt", 32'(wt[0]), 32'd0);
        check("dual_c3_np", 32'(np[0]), 32'd0);

        // Lone slot 1 under backpressure
        fs = 8'd0; v1 = 1'b1; t1 = 8'h30;
        step();
        v1 = 1'b0;
        check("lone_np", 32'(np[0]), 32'd1);
        check("lone_wt", 32'(wt[0]), 32'd0);
        step();
        check("lone_hold_src", 32'(src[0]), 32'h30);
        check("lone_hold_wt",  32'(wt[0]),  32'd0);
        fs = 8'd1;
        #1;
        check("lone_go_wt",  32'(wt[0]),  32'd1);
        check("lone_go_src", 32'(src[0]), 32'h30);
        step();
        check("lone_done_np", 32'(np[0]), 32'd0);

        // Fill to 7 entries, then drain in order
        fs = 8'd0;
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1; t0 = 8'(8'h40 + 2 * k); v1 = 1'b1; t1 = 8'(8'h41 + 2 * k);
            check("fill_rr", 32'(rr[0]), 32'd1);
            step();
        end
        v0 = 1'b1; t0 = 8'h46; v1 = 1'b0;
        check("fill_rr6", 32'(rr[0]), 32'd1);
        step();
        v0 = 1'b0;
        check("fill_np7", 32'(np[0]), 32'd7);
        check("fill_rr7", 32'(rr[0]), 32'd0);
        check("fill_ov",  32'(ov[0]), 32'd0);
        fs = 8'd5;
        for (int k = 0; k < 7; k++) begin
            #1;
            check("drain_wt",  32'(wt[0]),  32'd1);
            check("drain_src", 32'(src[0]), 32'(8'h40 + k));
            step();
        end
        check("drain_np", 32'(np[0]), 32'd0);
        do_reset();

        // Wrap on DEPTH=5: pairs pushed while draining one per cycle
        fs = 8'd1; idx = 0; cyc = 0; wlog.delete(); log_en = 1'b1;
        while ((idx < 13 || mq[1].size() != 0) && cyc < 200) begin
            if (idx < 13 && (md[1] - mq[1].size()) >= 2) begin
                v0 = 1'b1; t0 = 8'(8'h50 + idx); idx++;
                if (idx < 13) begin v1 = 1'b1; t1 = 8'(8'h50 + idx); idx++; end
                else v1 = 1'b0;
            end else begin
                v0 = 1'b0; v1 = 1'b0;
            end
            step();
            cyc++;
        end
        v0 = 1'b0; v1 = 1'b0; log_en = 1'b0;
        check("wrap_done", 32'(cyc < 200), 32'd1);
        check("wrap_len", 32'(wlog.size()), 32'd13);
        for (int k = 0; k < wlog.size(); k++)
            check("wrap_order", 32'(wlog[k]), 32'(8'h50 + k));
        check("wrap_ov5", 32'(ov[1]), 32'd0);
        do_reset();

        // Overflow: count=7, dual release drops the slot 1 tag
        fs = 8'd0;
        for (int k = 0; k < 3; k++) begin
            v0 = 1'b1; t0 = 8'(8'h70 + 2 * k); v1 = 1'b1; t1 = 8'(8'h71 + 2 * k);
            step();
        end
        v0 = 1'b1; t0 = 8'h76; v1 = 1'b0;
        step();
        v0 = 1'b1; t0 = 8'h60; v1 = 1'b1; t1 = 8'h61;
        check("ovf_rr", 32'(rr[0]), 32'd0);
        step();
        v0 = 1'b0; v1 = 1'b0;
        check("ovf_np", 32'(np[0]), 32'd8);
        check("ovf_set", 32'(ov[0]), 32'd1);
        fs = 8'd1;
        for (int k = 0; k < 7; k++) step();
        check("ovf_last_src", 32'(src[0]), 32'h60);
        check("ovf_last_wt",  32'(wt[0]),  32'd1);
        step();
        check("ovf_empty_np", 32'(np[0]), 32'd0);
        check("ovf_sticky",   32'(ov[0]), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(ov[0]), 32'd0);

        // Randomized traffic with occasional rule violations and resets
        for (int n = 0; n < 3000; n++) begin
            fs = ($urandom_range(0, 2) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            t0 = 8'($urandom);
            t1 = 8'($urandom);
            if ((md[0] - mq[0].size()) < 2 && $urandom_range(0, 15) != 0) v1 = 1'b0;
            reset_n = ($urandom_range(0, 299) != 0);
            step();
        end
        reset_n = 1'b1; v0 = 1'b0; v1 = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tag_release_buffer.md
# tag_release_buffer

Collects physical tags freed at commit (up to two per cycle) and returns them to the tag free list through its single-entry write port (`write_tag`/`write_tag_source`), one tag per cycle in commit order. It sits between the commit stage and the free list. It absorbs the 2-in/1-out rate mismatch and holds off returns while the free list reports no free space.

## Interface
Parameters:
- `DEPTH`, default 8: buffer entries. Legal range 2..255; non-power-of-2 is legal.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `rel_valid_0`  in  1  release slot 0 carries a freed tag (older of the pair).
- `rel_tag_0`  in  8  tag for slot 0.
- `rel_valid_1`  in  1  release slot 1 carries a freed tag (younger).
- `rel_tag_1`  in  8  tag for slot 1.
- `rel_ready`  out  1  at least two free entries; commit may release up to two tags this cycle.
- `fl_freespace`  in  8  free-list free-entry count; a write is allowed only when this is non-zero.
- `write_tag`  out  1  write strobe to the free list.
- `write_tag_source`  out  8  tag being returned.
- `num_pending`  out  8  entries currently held.
- `overflow`  out  1  sticky error: a release was dropped.

## Operation
- Circular buffer of `DEPTH` 8-bit entries. State: `head` and `tail` pointers (0..DEPTH-1), an 8-bit `count`, and the `overflow` flag. There is no other FSM.
- **Enqueue:** valid slots are compacted in slot order (slot 0 first).
  - A lone `rel_valid_1` occupies one entry.
  - Both valid: the slot 0 tag is written at `tail`, the slot 1 tag at `tail+1` (mod DEPTH).
  - `tail` advances by the number of tags accepted, wrapping modulo DEPTH. The +2 case wraps correctly from DEPTH-2 to 0 and from DEPTH-1 to 1.
- **Accept limit:** accepted = min(valid count, DEPTH - count), using the registered `count` (before any pop). Tags beyond the limit are dropped, the slot 1 tag first, and `overflow` is set.
- **Dequeue:**
  - `write_tag` = (count != 0) && (fl_freespace != 0). Combinational from registered state and `fl_freespace`.
  - `write_tag_source` = entry[head] when count != 0; otherwise 8'h00.
  - When `write_tag` is high, `head` advances by one, wrapping DEPTH-1 to 0.
- **Count update:** count_next = count + accepted - pop. A pop and enqueues in the same cycle are both applied.
- `rel_ready` = (DEPTH - count) >= 2, from registered `count`.
- `num_pending` = `count`.
- **overflow:** set on any dropped tag; cleared only by reset.
- **Reset** (reset_n low at an edge): head = tail = count = 0, overflow = 0. Release inputs in that cycle are ignored. Reset mid-operation discards all pending tags, because the free list reinitialises its own contents on the same reset.

## Timing
- Reset values of outputs: `write_tag`=0, `write_tag_source`=8'h00, `num_pending`=0, `overflow`=0, `rel_ready`=1.
- **Release-to-write latency:** a tag accepted at edge N is visible on `write_tag_source` from cycle N+1. There is no same-cycle bypass: in an empty buffer, `write_tag` stays low during the cycle of the release.
- **Throughput:** one tag returned per cycle while `fl_freespace` != 0.
- **Backpressure:** while `fl_freespace` is 0, `write_tag` stays low and `head` is held. The tag on `write_tag_source` stays stable until it is written.
- **Release rule:** commit must not assert more valid slots than `rel_ready` permits. With `rel_ready` low (free entries ≤ 1), at most one tag is accepted. Exceeding the rule drops tags and sets `overflow`; dropped tags are lost (error state).
- **Full buffer plus pop:** accept space is computed before the pop, so a full buffer that pops still accepts nothing that cycle.

## Test plan
- **Reset:** hold reset_n=0 for 2 cycles with rel_valid_0=1, rel_tag_0=8'h11. After release: num_pending=0, write_tag=0, rel_ready=1, overflow=0, and no 8'h11 is ever written.
- **Dual release:** rel_tag_0=8'h21, rel_tag_1=8'h22 both valid at cycle 0, fl_freespace=3. write_tag is high in cycles 1 and 2 with 8'h21 then 8'h22; low in cycle 3; num_pending sequence is 2,1,0.
- **Lone slot 1 plus backpressure:**
  - rel_valid_1 only, tag 8'h30, with fl_freespace=0: num_pending=1, write_tag=0.
  - Raise fl_freespace to 1: the next cycle returns 8'h30.
- **Fill and drain:** DEPTH=8, fl_freespace=0, push 8'h40..8'h46 (3 pairs then 1 single). rel_ready falls at count=7. Set fl_freespace=5: tags drain in push order, one per cycle.
- **Wrap:** DEPTH=5, fl_freespace=1, 13 tags 8'h50..8'h5C pushed in pairs while draining. Output order is identical to input order and overflow stays 0.
- **Overflow:** DEPTH=8, count=7, fl_freespace=0, dual release 8'h60/8'h61. 8'h60 is accepted, 8'h61 is dropped, overflow=1, and overflow stays 1 until reset_n=0.
